stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor of the combinational 4:1 narrow-data mux.
- Selects one of N_CH valid/ready input streams of WIDTH bits into a single registered output stream.
- Two modes: fixed channel (external select, as in the combinational mux) and round-robin arbitration.
- Sits between several producers and one consumer. Provides one-cycle latency, full throughput and backpressure.

Parameters:
- WIDTH, 8, data width per channel (>=1)
- N_CH, 4, number of input channels (>=2, need not be a power of two)
- SEL_W, $clog2(N_CH), width of sel and out_ch (derived; do not override)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- mode  input  1  0 = fixed (channel sel), 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_valid  input  N_CH  bit i = channel i offers a word
- in_data  input  N_CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_ready  output  N_CH  bit i = channel i word accepted this cycle (combinational)
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  held word
- out_ch  output  SEL_W  channel index the held word came from
- out_ready  input  1  consumer accepts the held word this cycle

Behaviour:
- Reset, synchronous and active-high: on the clock edge with rst=1, out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - A word held at that point is discarded.
  - in_ready is all-zero while rst=1.
- Output transfer: occurs when out_valid && out_ready.
- Load enable: load_en = !out_valid || out_ready. Because of this, a word can drain and a new word load in the same cycle, giving a throughput of 1 word/cycle.
- Grant, combinational, at most one channel:
  - mode=0: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant. An out-of-range sel never grants.
  - mode=1: grant = first i with in_valid[i], searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (modulo N_CH). No grant if in_valid is all-zero.
- in_ready[i] = load_en && (grant == i). All other bits are 0.
  - in_ready must not depend on in_valid of channel i alone; it is a function of the grant.
- Load: when a grant exists and load_en=1, on the next edge: out_valid=1, out_data=in_data of the granted channel, out_ch=grant.
- Drain without load: when load_en=1 and there is no grant, out_valid goes to 0 on the next edge. out_data and out_ch keep their last values.
- Stall: when out_valid && !out_ready, out_valid, out_data and out_ch are held stable, and all in_ready=0.
- Latency: an input word accepted at edge k is visible on out_data after edge k (one cycle).
- rr pointer:
  - On each load in mode=1, ptr = (grant+1) mod N_CH, with wrap from N_CH-1 to 0.
  - A load in mode=0 does not change ptr.
  - Changing mode does not clear ptr.
- Mode/sel changes take effect on the grant of the same cycle. A word already held is unaffected.
- Fairness, mode=1: with all channels valid continuously and out_ready=1, channels are served 0,1,…,N_CH-1,0,… with no channel served twice before every other requesting channel is served once.
- Width rule: data passes through unmodified. No arithmetic on data. The pointer increment wraps for non-power-of-two N_CH.
- The design requires no latches and no combinational path from out_data to in_ready. The out_ready→in_ready path is allowed.

Test Plan:
- Reset state: rst=1 for 2 cycles with in_valid=4'b1111 → out_valid=0, out_data=0, out_ch=0, in_ready=0. After rst drops with mode=1 and all valid, the first word comes from ch0.
- Fixed mode: mode=0, sel=2, in_data ch0..3 = 0x10,0x21,0x32,0x43, in_valid=4'b1111, out_ready=1 → in_ready=4'b0100 every cycle, out_data=0x32 and out_ch=2 from the cycle after the first accept. With sel=2 and in_valid[2]=0 → in_ready=0 and out_valid falls after one cycle.
- Round-robin wrap: mode=1, all valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 with matching data. Then with in_valid=4'b1001 → sequence 0,3,0,3 alternates.
- Backpressure: held word 0x21 from ch1, out_ready=0 for 3 cycles → out_data=0x21, out_ch=1 stable, in_ready=0. Releasing out_ready → 0x21 transfers and the next granted word (ch2) loads on the same edge, with no bubble.
- Non-power-of-two: N_CH=3, mode=1, all valid → out_ch 0,1,2,0,1,2. mode=0, sel=3 → no grant ever.
- Reset mid-operation: out_valid=1 holding 0x43 with out_ready=0, ptr=2, then rst=1 for one cycle → out_valid=0, word lost. The next round-robin grant with all valid is ch0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N_CH:1 valid/ready stream mux with fixed-select and round-robin modes.
// The output stage is one register deep: one cycle of latency and one word per cycle.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_data_q,  out_data_d;
    logic [SEL_W-1:0]       out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]       ptr_q,       ptr_d;

    logic                   load_en_c;
    logic                   grant_vld_c;
    logic [SEL_W-1:0]       grant_c;
    logic [WIDTH-1:0]       grant_data_c;

    // Grant: exact match on sel in fixed mode; in round-robin, scan ptr..N_CH-1 then 0..ptr-1.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        if (!mode) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!grant_vld_c && in_valid[i] && (SEL_W'(i) == sel)) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!grant_vld_c && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SEL_W'(i);
                end
            end
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!grant_vld_c && in_valid[i] && (SEL_W'(i) < ptr_q)) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SEL_W'(i);
                end
            end
        end
    end

    // Data mux driven by the grant index only.
    always_comb begin
        grant_data_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (grant_c == SEL_W'(i)) begin
                grant_data_c = in_data[i*int'(WIDTH) +: WIDTH];
            end
        end
    end

    // Next state and the combinational ready vector.
    always_comb begin
        load_en_c   = !out_valid_q || out_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        in_ready    = '0;

        if (load_en_c) begin
            if (grant_vld_c) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data_c;
                out_ch_d    = grant_c;
                if (mode) begin
                    ptr_d = (grant_c == SEL_W'(N_CH - 1)) ? '0 : grant_c + SEL_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end

        for (int i = 0; i < int'(N_CH); i++) begin
            in_ready[i] = !rst && load_en_c && grant_vld_c && (grant_c == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance and a 3-channel instance.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 4-channel DUT
    logic        rst, mode, out_ready;
    logic [1:0]  sel;
    logic [3:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    // 3-channel DUT
    logic        rst3, mode3, out_ready3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3, in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    logic [7:0] d4 [4];
    logic [7:0] d3 [3];

    stream_mux_rr #(.WIDTH(8), .N_CH(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .N_CH(3)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset4();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1; in_valid = 4'b1111;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++;
        if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        n_cmp++;
        if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin n_err++; $display("FAIL post_reset_ready: got %b want 0001", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_err++; $display("FAIL post_reset_first: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready0: got %b want 0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h32 || out_ch !== 2'd2 || in_ready !== 4'b0100) begin
                n_err++;
                $display("FAIL fixed_cyc%0d: got v=%b d=%h ch=%0d rdy=%b want v=1 d=32 ch=2 rdy=0100",
                         k, out_valid, out_data, out_ch, in_ready);
            end
        end
        in_valid = 4'b1011;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin n_err++; $display("FAIL fixed_noval_ready: got %b want 0000", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h32 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL fixed_drain: got v=%b d=%h ch=%0d want v=0 d=32 ch=2", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_wrap();
        logic [1:0] exp_ch;
        logic [1:0] seq2 [4];
        seq2[0] = 2'd0; seq2[1] = 2'd3; seq2[2] = 2'd0; seq2[3] = 2'd3;
        do_reset4();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ch = 2'(k % 4);
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== d4[exp_ch]) begin
                n_err++;
                $display("FAIL rr_all_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid, out_ch, out_data, exp_ch, d4[exp_ch]);
            end
        end
        in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_ch = seq2[k];
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== d4[exp_ch]) begin
                n_err++;
                $display("FAIL rr_1001_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid, out_ch, out_data, exp_ch, d4[exp_ch]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset4();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_ch !== 2'd1 || out_data !== 8'h21 || in_ready !== 4'b0000) begin
            n_err++; $display("FAIL bp_setup: got ch=%0d d=%h rdy=%b want ch=1 d=21 rdy=0000", out_ch, out_data, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1 || in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_stall%0d: got v=%b d=%h ch=%0d rdy=%b want v=1 d=21 ch=1 rdy=0000",
                         k, out_valid, out_data, out_ch, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h32 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL bp_no_bubble: got v=%b d=%h ch=%0d want v=1 d=32 ch=2", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_reset_mid();
        do_reset4();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        tick();
        tick();
        mode = 1'b0; sel = 2'd3;
        tick();
        out_ready = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h43 || out_ch !== 2'd3) begin
            n_err++; $display("FAIL mid_held: got v=%b d=%h ch=%0d want v=1 d=43 ch=3", out_valid, out_data, out_ch);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_err++; $display("FAIL mid_rst_state: got v=%b d=%h want v=0 d=00", out_valid, out_data);
        end
        rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_ready: got %b want 0001", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_err++; $display("FAIL mid_first: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_npot();
        logic [1:0] exp_ch;
        rst3 = 1'b1; mode3 = 1'b1; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        tick();
        rst3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_ch = 2'(k % 3);
            n_cmp++;
            if (out_valid3 !== 1'b1 || out_ch3 !== exp_ch || out_data3 !== d3[exp_ch]) begin
                n_err++;
                $display("FAIL npot_rr_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid3, out_ch3, out_data3, exp_ch, d3[exp_ch]);
            end
        end
        mode3 = 1'b0; sel3 = 2'd3;
        #1;
        n_cmp++;
        if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL npot_sel3_ready: got %b want 000", in_ready3); end
        tick();
        n_cmp++;
        if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL npot_sel3_valid: got %b want 0", out_valid3); end
        tick();
        n_cmp++;
        if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
            n_err++; $display("FAIL npot_sel3_hold: got rdy=%b v=%b want rdy=000 v=0", in_ready3, out_valid3);
        end
    endtask

    initial begin
        d4[0] = 8'h10; d4[1] = 8'h21; d4[2] = 8'h32; d4[3] = 8'h43;
        d3[0] = 8'hA0; d3[1] = 8'hB1; d3[2] = 8'hC2;
        in_data  = {d4[3], d4[2], d4[1], d4[0]};
        in_data3 = {d3[2], d3[1], d3[0]};
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b0;

        test_reset();
        test_fixed();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_npot();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
